plru_repl_engine: RTL
=====================

Name: plru_repl_engine

Overview:
- Parametrised tree-PLRU replacement engine for the set-associative LLC.
- Owns the per-set PLRU bit storage (N_WAY-1 bits per set) for NUM_SETS sets.
- Applies access updates from the lookup/fill path and returns victim ways on request.
- An invalid way, flagged by the caller's invalid mask, is always preferred over the tree choice.
- Sits beside the tag/MESI array; the controller issues an update on every hit and every fill.

Parameters:
N_WAY, 16, associativity; power of 2, >=2; otherwise elaboration error
NUM_SETS, 16384, number of sets; power of 2, >=2
INDEX_SIZE, $clog2(NUM_SETS), set index width
WAY_W, $clog2(N_WAY), way number width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
init_done  out  1  high once the storage sweep has completed
upd_valid  in  1  access update strobe
upd_index  in  INDEX_SIZE  set being updated
upd_way  in  WAY_W  way being marked most-recently-used
vic_req_valid  in  1  victim request
vic_req_ready  out  1  equals init_done
vic_index  in  INDEX_SIZE  set being queried
vic_inval_mask  in  N_WAY  bit w=1 means way w is MESI I
vic_rsp_valid  out  1  one-cycle response pulse
vic_way  out  WAY_W  chosen victim way
vic_from_inval  out  1  victim came from the invalid mask
stat_upd_cnt  out  32  accepted updates (optional feature)
stat_vic_cnt  out  32  accepted victim requests (optional feature)
stat_inval_cnt  out  32  victims taken from the invalid mask (optional feature)

Behaviour:
- Reset values: init_done=0, vic_req_ready=0, vic_rsp_valid=0, vic_way=0, vic_from_inval=0, all stat counters=0.
- FSM states are INIT and RUN.
  - rst forces INIT with sweep pointer 0.
  - INIT writes all-zero bits to one set per cycle, starting with the first cycle rst is low.
  - After set NUM_SETS-1 is written, the FSM moves to RUN; init_done=1 exactly NUM_SETS cycles after rst deasserts.
- upd_valid and vic_req_valid are ignored while in INIT.
- Tree encoding:
  - Node 0 is the root; node i has children 2i+1 and 2i+2.
  - Leaf node n corresponds to way n-(N_WAY-1).
  - Bit=0 means the victim is on the left (lower ways); bit=1 means the right.
- Update of way w: every node on the root-to-w path is set to point away from w. All other bits are unchanged.
- Victim selection:
  - If vic_inval_mask!=0: vic_way = lowest-index set bit, vic_from_inval=1.
  - Otherwise: walk the tree from the root following the bits; vic_from_inval=0.
  - A victim query never modifies PLRU bits. The controller issues an update on fill.
- Latency and throughput:
  - Request accepted in cycle T (valid & ready); vic_rsp_valid=1 in cycle T+2 for exactly one cycle.
  - The block accepts one request per cycle, fully pipelined.
  - There is no response backpressure.
- Update and victim requests may be asserted in the same cycle, including to the same set.
- Ordering: the victim response for a request accepted in cycle T reflects every update accepted in cycles <=T.
  - A same-cycle update is applied first.
  - Pending read-modify-write results must be forwarded; stale storage reads are forbidden.
- Back-to-back updates to the same set in consecutive cycles compose correctly, each on top of the previous result.
- rst mid-operation:
  - In-flight responses are dropped; vic_rsp_valid=0 from the next cycle.
  - The INIT sweep restarts from set 0.
- Boundaries:
  - upd_index / vic_index = NUM_SETS-1 is valid.
  - vic_inval_mask all-ones gives way 0.
  - Only the most-significant mask bit set gives way N_WAY-1.

Optional Feature:
- Macro: PLRU_STATS_EN.
- Defined:
  - Three 32-bit saturating counters, cleared by rst and held at 0 during INIT.
  - stat_upd_cnt +1 per accepted update.
  - stat_vic_cnt +1 per accepted victim request.
  - stat_inval_cnt +1 per response with vic_from_inval=1.
  - Counters stick at 0xFFFF_FFFF.
- Undefined: stat ports are tied to 0 and no counter logic is built.

Test Plan:
- All tests use N_WAY=4, NUM_SETS=8.
- Init: deassert rst at cycle 0 -> init_done=0 for cycles 0-7, 1 at cycle 8; vic_req_valid held high during INIT produces no response.
- Fresh set: victim set 3, mask 0 -> vic_way=0, vic_from_inval=0, two cycles after accept.
- Update set 3 way 0, then victim set 3 -> way 2. Update set 3 way 2, then victim -> way 1. Set 4 still returns way 0.
- Same-cycle update set 5 way 0 plus victim set 5 mask 0 -> response way 2 (forwarded). Updates way 0 then way 2 in consecutive cycles, then victim -> way 1.
- Mask 4'b1010 -> vic_way=1, vic_from_inval=1. Mask 4'b1111 -> way 0. Neither request changes the tree: the next victim with mask 0 is unchanged.
- Assert rst one cycle after a victim accept -> no vic_rsp_valid pulse. INIT restarts, and after init set 3 again returns way 0. With PLRU_STATS_EN, counters read 0 after reset.

Source files
------------

// File: rtl/plru_repl_engine.sv
// Tree-PLRU replacement engine: per-set PLRU bits, MRU updates, victim selection with invalid ways preferred.
// Victim response 2 cycles after accept with no response backpressure. Define PLRU_STATS_EN to build the stat counters.
module plru_repl_engine #(
  parameter int N_WAY      = 16,
  parameter int NUM_SETS   = 16384,
  parameter int INDEX_SIZE = $clog2(NUM_SETS),
  parameter int WAY_W      = $clog2(N_WAY)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  upd_valid,
  input  logic [INDEX_SIZE-1:0] upd_index,
  input  logic [WAY_W-1:0]      upd_way,
  input  logic                  vic_req_valid,
  output logic                  vic_req_ready,
  input  logic [INDEX_SIZE-1:0] vic_index,
  input  logic [N_WAY-1:0]      vic_inval_mask,
  output logic                  vic_rsp_valid,
  output logic [WAY_W-1:0]      vic_way,
  output logic                  vic_from_inval,
  output logic [31:0]           stat_upd_cnt,
  output logic [31:0]           stat_vic_cnt,
  output logic [31:0]           stat_inval_cnt
);

  if (N_WAY < 2 || (N_WAY & (N_WAY - 1)) != 0) begin : g_bad_n_way
    $error("plru_repl_engine: N_WAY must be a power of 2 and >= 2");
  end
  if (NUM_SETS < 2 || (NUM_SETS & (NUM_SETS - 1)) != 0) begin : g_bad_num_sets
    $error("plru_repl_engine: NUM_SETS must be a power of 2 and >= 2");
  end

  localparam int NB = N_WAY - 1;
  localparam int XW = WAY_W + 1;

  typedef logic [NB-1:0] bits_t;
  typedef enum logic {INIT, RUN} state_t;

  // Node indices are walked over a zero-padded copy so the index width matches the vector.
  function automatic bits_t tree_touch(bits_t b, logic [WAY_W-1:0] w);
    logic [2*N_WAY-1:0] ext;
    logic [XW-1:0]      n;
    logic [WAY_W-1:0]   ws;
    logic               d;
    ext = {{(N_WAY+1){1'b0}}, b};
    n   = '0;
    ws  = w;
    for (int l = 0; l < WAY_W; l++) begin
      d      = ws[WAY_W-1];
      ext[n] = ~d;
      n      = {n[XW-2:0], 1'b0} + XW'(1) + XW'(d);
      ws     = ws << 1;
    end
    return ext[NB-1:0];
  endfunction

  function automatic logic [WAY_W-1:0] tree_victim(bits_t b);
    logic [2*N_WAY-1:0] ext;
    logic [XW-1:0]      n;
    logic [WAY_W-1:0]   w;
    logic               d;
    ext = {{(N_WAY+1){1'b0}}, b};
    n   = '0;
    w   = '0;
    for (int l = 0; l < WAY_W; l++) begin
      d = ext[n];
      w = (w << 1) | WAY_W'(d);
      n = {n[XW-2:0], 1'b0} + XW'(1) + XW'(d);
    end
    return w;
  endfunction

  function automatic logic [WAY_W-1:0] lowest_set(logic [N_WAY-1:0] m);
    logic [N_WAY-1:0] ms;
    logic             found;
    logic [WAY_W-1:0] w;
    ms    = m;
    found = 1'b0;
    w     = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (!found && ms[0]) begin
        w     = WAY_W'(i);
        found = 1'b1;
      end
      ms = ms >> 1;
    end
    return w;
  endfunction

  state_t                state;
  logic [INDEX_SIZE-1:0] sweep_ptr;
  bits_t                 mem [NUM_SETS];

  logic                  upd_acc, vic_acc;
  logic                  u1_vld, v1_vld, wr_vld;
  logic [INDEX_SIZE-1:0] u1_idx, v1_idx, wr_idx;
  logic [WAY_W-1:0]      u1_way;
  logic [N_WAY-1:0]      v1_mask;
  bits_t                 u1_rd, v1_rd, wr_dat;
  bits_t                 u1_base, u1_new, v1_base;
  logic [WAY_W-1:0]      v1_way;
  logic                  v1_inval;

  assign vic_req_ready = init_done;
  assign upd_acc       = upd_valid & init_done;
  assign vic_acc       = vic_req_valid & init_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      sweep_ptr <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          sweep_ptr <= sweep_ptr + INDEX_SIZE'(1);
          if (sweep_ptr == INDEX_SIZE'(NUM_SETS - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: ;
      endcase
    end
  end

  // Storage reads land one cycle after accept; the write retired at the previous edge
  // and the update in flight this cycle are newer than what the read returned.
  always_comb begin
    u1_base = (wr_vld && (wr_idx == u1_idx)) ? wr_dat : u1_rd;
    u1_new  = tree_touch(u1_base, u1_way);
    v1_base = v1_rd;
    if (wr_vld && (wr_idx == v1_idx)) v1_base = wr_dat;
    if (u1_vld && (u1_idx == v1_idx)) v1_base = u1_new;
    v1_inval = |v1_mask;
    v1_way   = v1_inval ? lowest_set(v1_mask) : tree_victim(v1_base);
  end

  always_ff @(posedge clk) begin
    u1_rd   <= mem[upd_index];
    v1_rd   <= mem[vic_index];
    u1_idx  <= upd_index;
    u1_way  <= upd_way;
    v1_idx  <= vic_index;
    v1_mask <= vic_inval_mask;
    wr_idx  <= u1_idx;
    wr_dat  <= u1_new;
    if (!init_done) mem[sweep_ptr] <= '0;
    else if (u1_vld) mem[u1_idx] <= u1_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u1_vld         <= 1'b0;
      v1_vld         <= 1'b0;
      wr_vld         <= 1'b0;
      vic_rsp_valid  <= 1'b0;
      vic_way        <= '0;
      vic_from_inval <= 1'b0;
    end else begin
      u1_vld        <= upd_acc;
      v1_vld        <= vic_acc;
      wr_vld        <= u1_vld;
      vic_rsp_valid <= v1_vld;
      if (v1_vld) begin
        vic_way        <= v1_way;
        vic_from_inval <= v1_inval;
      end
    end
  end

`ifdef PLRU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || !init_done) begin
      stat_upd_cnt   <= '0;
      stat_vic_cnt   <= '0;
      stat_inval_cnt <= '0;
    end else begin
      if (upd_acc && (stat_upd_cnt != '1)) stat_upd_cnt <= stat_upd_cnt + 32'd1;
      if (vic_acc && (stat_vic_cnt != '1)) stat_vic_cnt <= stat_vic_cnt + 32'd1;
      if (v1_vld && v1_inval && (stat_inval_cnt != '1)) stat_inval_cnt <= stat_inval_cnt + 32'd1;
    end
  end
`else
  assign stat_upd_cnt   = '0;
  assign stat_vic_cnt   = '0;
  assign stat_inval_cnt = '0;
`endif

endmodule
